// File: rtl/alu_result_writeback.sv
// rtl/alu_result_writeback.sv - ALUOut register plus two-entry write-back queue with forwarding
//
// Purpose:
//   Registers the ALU result every cycle (ALUOut) and returns completed results
//   to the register file write port. It selects the write-back source (ALU result
//   or memory data) for each request. Up to two pending writes are held while the
//   register file port stalls. Pending entries are also exposed to the operand
//   path as forwarding hits.
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   alu_result, alu_out   combinational ALU output in; registered ALUOut out
//   mem_data              memory data register value
//   in_valid / in_ready   write-back request handshake
//   in_mem_to_reg         1 = write mem_data, 0 = write alu_result
//   in_reg_write, in_dest request writes a register / destination index
//   rf_we / rf_ready      head-entry write request / register file accepts
//   rf_waddr, rf_wdata    head-entry index and data
//   fwd_addr_a/b          operand source indices to look up
//   fwd_hit_a/b           a pending entry targets that index
//   fwd_data_a/b          youngest matching entry data (0 when no hit)

module alu_result_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    input  logic [ADDR_W-1:0] in_dest,
    output logic              rf_we,
    input  logic              rf_ready,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [ADDR_W-1:0] fwd_addr_a,
    input  logic [ADDR_W-1:0] fwd_addr_b,
    output logic              fwd_hit_a,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_b
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] entry_addr [2];
    logic [DATA_W-1:0] entry_data [2];
    logic              head;
    logic              tail;
    logic              young;

    logic              accept;
    logic              enq;
    logic              retire;
    logic [DATA_W-1:0] enq_data;

    // Handshake and drain request are decoded from the state register only,
    // so there is no combinational path from rf_ready to in_ready.
    assign in_ready = (state != S_FULL);
    assign rf_we    = (state != S_EMPTY);

    assign accept   = in_valid & in_ready;
    // Requests that do not write, or that target register 0, are consumed
    // without occupying a slot.
    assign enq      = accept & in_reg_write & (in_dest != '0);
    assign retire   = rf_we & rf_ready;
    assign enq_data = in_mem_to_reg ? mem_data : alu_result;

    // Pointers are one bit wide, so the youngest entry (tail-1) is ~tail.
    assign young    = ~tail;

    assign rf_waddr = rf_we ? entry_addr[head] : '0;
    assign rf_wdata = rf_we ? entry_data[head] : '0;

    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: begin
                if (enq) begin
                    state_next = S_ONE;
                end
            end
            S_ONE: begin
                if (enq && !retire) begin
                    state_next = S_FULL;
                end else if (!enq && retire) begin
                    state_next = S_EMPTY;
                end
            end
            S_FULL: begin
                if (retire) begin
                    state_next = S_ONE;
                end
            end
            default: begin
                state_next = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_EMPTY;
            alu_out <= '0;
            head    <= 1'b0;
            tail    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                entry_addr[i] <= '0;
                entry_data[i] <= '0;
            end
        end else begin
            state   <= state_next;
            alu_out <= alu_result;
            if (enq) begin
                entry_addr[tail] <= in_dest;
                entry_data[tail] <= enq_data;
                tail             <= ~tail;
            end
            if (retire) begin
                head <= ~head;
            end
        end
    end

    // Forwarding looks at stored entries only. The older entry is checked
    // first, so a match on the youngest entry overrides it. The head entry
    // still counts as a hit on the cycle it retires.
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        if (fwd_addr_a != '0) begin
            if ((state == S_FULL) && (entry_addr[head] == fwd_addr_a)) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = entry_data[head];
            end
            if ((state != S_EMPTY) && (entry_addr[young] == fwd_addr_a)) begin
                fwd_hit_a  = 1'b1;
                fwd_data_a = entry_data[young];
            end
        end
    end

    always_comb begin
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        if (fwd_addr_b != '0) begin
            if ((state == S_FULL) && (entry_addr[head] == fwd_addr_b)) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = entry_data[head];
            end
            if ((state != S_EMPTY) && (entry_addr[young] == fwd_addr_b)) begin
                fwd_hit_b  = 1'b1;
                fwd_data_b = entry_data[young];
            end
        end
    end

endmodule

// File: tb/tb_alu_result_writeback.sv
// tb/tb_alu_result_writeback.sv - self-checking bench for alu_result_writeback

module tb_alu_result_writeback;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] alu_result = '0;
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] mem_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_mem_to_reg = 1'b0;
    logic              in_reg_write = 1'b0;
    logic [ADDR_W-1:0] in_dest = '0;
    logic              rf_we;
    logic              rf_ready = 1'b0;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [ADDR_W-1:0] fwd_addr_a = '0;
    logic [ADDR_W-1:0] fwd_addr_b = '0;
    logic              fwd_hit_a;
    logic [DATA_W-1:0] fwd_data_a;
    logic              fwd_hit_b;
    logic [DATA_W-1:0] fwd_data_b;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    alu_result_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .alu_result   (alu_result),
        .alu_out      (alu_out),
        .mem_data     (mem_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mem_to_reg(in_mem_to_reg),
        .in_reg_write (in_reg_write),
        .in_dest      (in_dest),
        .rf_we        (rf_we),
        .rf_ready     (rf_ready),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .fwd_addr_a   (fwd_addr_a),
        .fwd_addr_b   (fwd_addr_b),
        .fwd_hit_a    (fwd_hit_a),
        .fwd_data_a   (fwd_data_a),
        .fwd_hit_b    (fwd_hit_b),
        .fwd_data_b   (fwd_data_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic request(input logic [ADDR_W-1:0] dest, input logic [DATA_W-1:0] val,
                           input logic use_mem, input logic wr);
        in_valid      = 1'b1;
        in_dest       = dest;
        in_reg_write  = wr;
        in_mem_to_reg = use_mem;
        if (use_mem) mem_data = val; else alu_result = val;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        alu_result = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (alu_out !== '0 || rf_we !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_state cyc%0d: alu_out=%h rf_we=%b in_ready=%b, want 0/0/1",
                         i, alu_out, rf_we, in_ready);
            end
            vectors++;
            if (rf_waddr !== '0 || rf_wdata !== '0 || fwd_hit_a !== 1'b0 || fwd_hit_b !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: waddr=%h wdata=%h hit_a=%b hit_b=%b, want all 0",
                         rf_waddr, rf_wdata, fwd_hit_a, fwd_hit_b);
            end
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (alu_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL alu_out_after_reset: got %h want deadbeef", alu_out);
        end
    endtask

    task automatic test_single_write();
        rf_ready = 1'b1;
        request(5'd5, 32'h1234, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
            errors++;
            $display("FAIL single_write: we=%b addr=%0d data=%h, want 1/5/1234", rf_we, rf_waddr, rf_wdata);
        end
        tick();
        vectors++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL single_write_done: rf_we=%b want 0", rf_we);
        end
    endtask

    task automatic test_stall_fill();
        rf_ready = 1'b0;
        request(5'd3, 32'hA, 1'b0, 1'b1);
        tick();
        request(5'd4, 32'hB, 1'b0, 1'b1);
        tick();
        request(5'd6, 32'hC, 1'b0, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 1'b0 || rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA) begin
            errors++;
            $display("FAIL stall_full: in_ready=%b we=%b addr=%0d data=%h, want 0/1/3/a",
                     in_ready, rf_we, rf_waddr, rf_wdata);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (in_ready !== 1'b0 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA) begin
            errors++;
            $display("FAIL stall_hold: in_ready=%b addr=%0d data=%h, want 0/3/a", in_ready, rf_waddr, rf_wdata);
        end
        rf_ready = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'hB) begin
            errors++;
            $display("FAIL drain_second: in_ready=%b we=%b addr=%0d data=%h, want 1/1/4/b",
                     in_ready, rf_we, rf_waddr, rf_wdata);
        end
        tick();
        vectors++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: rf_we=%b want 0 (third request must be dropped)", rf_we);
        end
    endtask

    task automatic test_discard();
        rf_ready = 1'b1;
        request(5'd0, 32'h55, 1'b0, 1'b1);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL discard_r0_ready: in_ready=%b want 1", in_ready);
        end
        tick();
        request(5'd7, 32'h66, 1'b0, 1'b0);
        #1;
        vectors++;
        if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL discard_r0: rf_we=%b in_ready=%b want 0/1", rf_we, in_ready);
        end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL discard_nowrite: rf_we=%b want 0", rf_we);
        end
        tick();
        vectors++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL discard_late: rf_we=%b want 0", rf_we);
        end
    endtask

    task automatic test_forwarding();
        rf_ready = 1'b0;
        request(5'd9, 32'h11, 1'b1, 1'b1);
        tick();
        request(5'd9, 32'h22, 1'b1, 1'b1);
        tick();
        in_valid   = 1'b0;
        fwd_addr_a = 5'd9;
        fwd_addr_b = 5'd0;
        #1;
        vectors++;
        if (fwd_hit_a !== 1'b1 || fwd_data_a !== 32'h22 || fwd_hit_b !== 1'b0 || fwd_data_b !== '0) begin
            errors++;
            $display("FAIL fwd_youngest: hit_a=%b data_a=%h hit_b=%b data_b=%h, want 1/22/0/0",
                     fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b);
        end
        rf_ready = 1'b1;
        #1;
        vectors++;
        if (fwd_hit_a !== 1'b1 || rf_wdata !== 32'h11) begin
            errors++;
            $display("FAIL fwd_retiring: hit_a=%b wdata=%h, want 1/11", fwd_hit_a, rf_wdata);
        end
        tick();
        tick();
        vectors++;
        if (fwd_hit_a !== 1'b0 || fwd_data_a !== '0) begin
            errors++;
            $display("FAIL fwd_cleared: hit_a=%b data_a=%h, want 0/0", fwd_hit_a, fwd_data_a);
        end
    endtask

    task automatic test_reset_midop();
        rf_ready = 1'b0;
        request(5'd1, 32'h101, 1'b0, 1'b1);
        tick();
        request(5'd2, 32'h202, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
        vectors++;
        if (rf_we !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_midop: rf_we=%b in_ready=%b want 0/1", rf_we, in_ready);
        end
        rf_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (rf_we !== 1'b0) begin
                errors++;
                $display("FAIL reset_midop_nowrite cyc%0d: rf_we=%b want 0", i, rf_we);
            end
        end
    endtask

    // Reference model: an ordered list of pending {addr,data} writes, oldest first.
    task automatic test_random();
        logic [ADDR_W+DATA_W-1:0] q[$];
        logic [DATA_W-1:0]        prev_alu;
        logic                     exp_hit_a, exp_hit_b, do_retire, do_accept;
        logic [DATA_W-1:0]        exp_data_a, exp_data_b, val;
        q.delete();
        for (int cyc = 0; cyc < 400; cyc++) begin
            alu_result    = $urandom;
            mem_data      = $urandom;
            in_valid      = ($urandom_range(0, 3) != 0);
            in_mem_to_reg = $urandom_range(0, 1);
            in_reg_write  = ($urandom_range(0, 7) != 0);
            in_dest       = ADDR_W'($urandom_range(0, 3));
            rf_ready      = ($urandom_range(0, 2) == 0);
            fwd_addr_a    = ADDR_W'($urandom_range(0, 3));
            fwd_addr_b    = ADDR_W'($urandom_range(0, 3));
            #1;
            exp_hit_a = 1'b0; exp_data_a = '0;
            exp_hit_b = 1'b0; exp_data_b = '0;
            for (int k = 0; k < q.size(); k++) begin
                if (fwd_addr_a != 0 && q[k][ADDR_W+DATA_W-1:DATA_W] == fwd_addr_a) begin
                    exp_hit_a = 1'b1; exp_data_a = q[k][DATA_W-1:0];
                end
                if (fwd_addr_b != 0 && q[k][ADDR_W+DATA_W-1:DATA_W] == fwd_addr_b) begin
                    exp_hit_b = 1'b1; exp_data_b = q[k][DATA_W-1:0];
                end
            end
            vectors++;
            if (in_ready !== (q.size() != 2) || rf_we !== (q.size() != 0)) begin
                errors++;
                $display("FAIL rand_flags cyc%0d: in_ready=%b rf_we=%b, want %b/%b",
                         cyc, in_ready, rf_we, q.size() != 2, q.size() != 0);
            end
            if (q.size() != 0) begin
                vectors++;
                if ({rf_waddr, rf_wdata} !== q[0]) begin
                    errors++;
                    $display("FAIL rand_head cyc%0d: got %h want %h", cyc, {rf_waddr, rf_wdata}, q[0]);
                end
            end
            vectors++;
            if (fwd_hit_a !== exp_hit_a || fwd_data_a !== exp_data_a ||
                fwd_hit_b !== exp_hit_b || fwd_data_b !== exp_data_b) begin
                errors++;
                $display("FAIL rand_fwd cyc%0d: a=%b/%h b=%b/%h want a=%b/%h b=%b/%h", cyc,
                         fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b,
                         exp_hit_a, exp_data_a, exp_hit_b, exp_data_b);
            end
            do_retire = (q.size() != 0) && rf_ready;
            do_accept = in_valid && (q.size() != 2);
            val       = in_mem_to_reg ? mem_data : alu_result;
            prev_alu  = alu_result;
            tick();
            if (do_retire) void'(q.pop_front());
            if (do_accept && in_reg_write && in_dest != 0) q.push_back({in_dest, val});
            vectors++;
            if (alu_out !== prev_alu) begin
                errors++;
                $display("FAIL rand_alu_out cyc%0d: got %h want %h", cyc, alu_out, prev_alu);
            end
        end
        in_valid = 1'b0;
        rf_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_stall_fill();
        test_discard();
        test_forwarding();
        test_reset_midop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/alu_result_writeback.md
Name: alu_result_writeback

Overview:
- Back end of the execute path: registers the ALU result (ALUOut) and returns completed results to the register file write port.
- Selects the write-back source (ALU result or memory data) and queues up to two pending writes when the register file port stalls.
- Reports forwarding hits so the operand path can bypass pending writes.
- Sits between the ALU/memory-data stage and the register file write port. It is the write-side counterpart of the register-file-read / ALU-operand registers.

Parameters:
- DATA_W, 32, width of result data.
- ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- alu_result  in  DATA_W  combinational ALU output.
- alu_out  out  DATA_W  ALUOut register; captures alu_result every cycle.
- mem_data  in  DATA_W  memory data register value.
- in_valid  in  1  a write-back request is presented this cycle.
- in_ready  out  1  block can accept a request.
- in_mem_to_reg  in  1  1 = write mem_data, 0 = write alu_result.
- in_reg_write  in  1  request actually writes a register.
- in_dest  in  ADDR_W  destination register index.
- rf_we  out  1  write request to the register file (head entry valid).
- rf_ready  in  1  register file accepts the write this cycle.
- rf_waddr  out  ADDR_W  head entry register index.
- rf_wdata  out  DATA_W  head entry data.
- fwd_addr_a  in  ADDR_W  operand A source index to check.
- fwd_addr_b  in  ADDR_W  operand B source index to check.
- fwd_hit_a  out  1  a pending entry targets fwd_addr_a.
- fwd_data_a  out  DATA_W  data for that hit.
- fwd_hit_b  out  1  a pending entry targets fwd_addr_b.
- fwd_data_b  out  DATA_W  data for that hit.

Behaviour:
- Reset (synchronous, priority over everything):
  - alu_out=0, count=0, head/tail pointers=0, entries cleared.
  - rf_we=0, rf_waddr=0, rf_wdata=0, fwd_hit_a/b=0.
  - Pending entries are discarded on reset mid-operation; no write is issued on the reset cycle.
- alu_out: alu_result is registered every non-reset cycle, independent of in_valid. Latency 1.
- Buffer: 2-entry FIFO with state EMPTY/ONE/FULL (count 0/1/2). in_ready = (count != 2), a registered function of state with no combinational path from rf_ready.
- Accept when in_valid & in_ready:
  - Entry data = in_mem_to_reg ? mem_data : alu_result, sampled that cycle. Entry addr = in_dest.
  - If in_reg_write=0 or in_dest=0, the request is consumed but not enqueued; count is unchanged. Register 0 is never written.
- Drain: rf_we = (count != 0). rf_waddr and rf_wdata show the head entry.
  - A write retires on a cycle with rf_we & rf_ready; the head advances next cycle.
  - While rf_ready=0, rf_we, rf_waddr and rf_wdata hold stable.
- Simultaneous accept and retire:
  - EMPTY: the accepted entry appears at the head next cycle (no same-cycle bypass). Minimum request-to-rf_we latency is 1 cycle.
  - ONE: count stays 1; the new entry becomes the head.
  - FULL: in_ready=0, so only the retire occurs; the state becomes ONE.
- State transitions:
  - EMPTY -> ONE on an enqueue.
  - ONE -> FULL on an enqueue without retire.
  - ONE -> EMPTY on a retire without enqueue.
  - FULL -> ONE on a retire.
  - All other cases hold state.
- Pointers wrap modulo 2.
- Forwarding (combinational from stored entries only, not from the in_* request):
  - fwd_hit_x = 1 if any valid entry has addr == fwd_addr_x and fwd_addr_x != 0.
  - If both entries match, fwd_data_x is the youngest (tail-1) entry's data.
  - If there is no hit, fwd_data_x = 0.
  - An entry retiring this cycle still counts as a hit this cycle.
- Width: data is passed through unmodified; there is no arithmetic.

Test Plan:
- Reset with alu_result=0xDEADBEEF applied for 3 cycles while reset=1 -> alu_out=0, rf_we=0, in_ready=1. First cycle after release -> alu_out=0xDEADBEEF.
- Single write, rf_ready=1: in_valid with in_dest=5, in_mem_to_reg=0, alu_result=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234. Following cycle rf_we=0.
- Stall and fill: rf_ready=0, two requests (r3=0xA, r4=0xB) -> in_ready=0 and rf_we=1 holding r3/0xA; a third in_valid is not accepted. Raise rf_ready -> writes r3 then r4 on consecutive cycles; in_ready=1 after the first retire.
- Discard cases: in_dest=0 with in_reg_write=1, and in_dest=7 with in_reg_write=0 -> both accepted (in_ready=1), count stays 0, rf_we never asserts.
- Forwarding with rf_ready=0:
  - Enqueue r9=0x11 then r9=0x22 (mem_to_reg=1, mem_data) with fwd_addr_a=9, fwd_addr_b=0 -> fwd_hit_a=1, fwd_data_a=0x22, fwd_hit_b=0.
  - After both retire -> fwd_hit_a=0.
- Reset mid-operation: FULL with rf_ready=0, assert reset for 1 cycle -> next cycle count=0, rf_we=0, in_ready=1. Neither entry is ever written.
